reservation_station: RTL and testbench

- Consumer end of the decoder issue bus for non-memory instructions: arithmetic, branch, JAL/JALR, LUI and AUIPC.
- Buffers issued instructions until both operands are resolved. Resolution comes from ALU and LSB load broadcasts.
- Dispatches one ready instruction per cycle to the ALU.
- Sits between the decoder (issue side), the ALU (dispatch side) and the result broadcast buses (snoop side).

---
 rtl/reservation_station_pkg.sv | 72 +++++++
 rtl/reservation_station_select.sv | 24 ++
 rtl/reservation_station.sv | 176 +++++++++++++++++
 tb/tb_reservation_station.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reservation_station_pkg.sv
// Shared widths, opcode enumeration and operand helpers for the reservation station.
// Any unit that snoops the result buses can reuse snoop_operand.
package reservation_station_pkg;

    localparam int RS_SIZE   = 16;
    localparam int ROB_POS_W = 5;
    localparam int OPENUM_W  = 6;
    localparam int DATA_W    = 32;
    localparam int RS_IDX_W  = $clog2(RS_SIZE);
    localparam int RS_CNT_W  = RS_IDX_W + 1;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [OPENUM_W-1:0] {
        OP_NONE  = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_BLTU  = 6'd9,
        OP_BGEU  = 6'd10,
        OP_ADDI  = 6'd11,
        OP_SLTI  = 6'd12,
        OP_XORI  = 6'd13,
        OP_ORI   = 6'd14,
        OP_ANDI  = 6'd15,
        OP_ADD   = 6'd16,
        OP_SUB   = 6'd17,
        OP_SLL   = 6'd18,
        OP_SLT   = 6'd19,
        OP_XOR   = 6'd20,
        OP_SRL   = 6'd21,
        OP_SRA   = 6'd22,
        OP_OR    = 6'd23,
        OP_AND   = 6'd24
    } openum_e;

    // Tag 0 means the value field already holds the operand.
    typedef struct packed {
        logic [ROB_POS_W-1:0] tag;
        logic [DATA_W-1:0]    val;
    } operand_t;

    function automatic operand_t snoop_operand(
        input operand_t             op,
        input logic                 alu_rdy,
        input logic [ROB_POS_W-1:0] alu_pos,
        input logic [DATA_W-1:0]    alu_val,
        input logic                 lsb_rdy,
        input logic [ROB_POS_W-1:0] lsb_pos,
        input logic [DATA_W-1:0]    lsb_val
    );
        operand_t res;
        res = op;
        if (op.tag != '0) begin
            if (alu_rdy && (op.tag == alu_pos)) begin
                res.tag = '0;
                res.val = alu_val;
            end else if (lsb_rdy && (op.tag == lsb_pos)) begin
                res.tag = '0;
                res.val = lsb_val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Lowest-index priority encoder: reports whether any bit of i_vec is set and
// the index of the lowest set bit.
module reservation_station_select #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_vec,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_found = 1'b1;
                o_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Reservation station for non-memory instructions: buffers issued ops until both
// operands are resolved by ALU/load broadcasts, then dispatches one per cycle.
module reservation_station
    import reservation_station_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 clr,
    input  logic                 issue_enable,
    input  logic                 rs_enable,
    input  logic [OPENUM_W-1:0]  issue_openum,
    input  logic [DATA_W-1:0]    issue_rs1_val,
    input  logic [ROB_POS_W-1:0] issue_rs1_rob_pos,
    input  logic [DATA_W-1:0]    issue_rs2_val,
    input  logic [ROB_POS_W-1:0] issue_rs2_rob_pos,
    input  logic [DATA_W-1:0]    issue_imm,
    input  logic [DATA_W-1:0]    issue_pc,
    input  logic [ROB_POS_W-1:0] issue_rob_pos,
    input  logic                 alu_result_ready,
    input  logic [ROB_POS_W-1:0] alu_result_rob_pos,
    input  logic [DATA_W-1:0]    alu_result_val,
    input  logic                 lsb_load_result_ready,
    input  logic [ROB_POS_W-1:0] lsb_load_result_rob_pos,
    input  logic [DATA_W-1:0]    lsb_load_result_val,
    output logic                 rs_full,
    output logic                 alu_enable,
    output logic [OPENUM_W-1:0]  alu_openum,
    output logic [DATA_W-1:0]    alu_val1,
    output logic [DATA_W-1:0]    alu_val2,
    output logic [DATA_W-1:0]    alu_imm,
    output logic [DATA_W-1:0]    alu_pc,
    output logic [ROB_POS_W-1:0] alu_rob_pos
);

    localparam logic [RS_CNT_W-1:0] FULL_MARK = RS_CNT_W'(RS_SIZE - 1);

    logic [RS_SIZE-1:0]   r_busy;
    logic [OPENUM_W-1:0]  r_openum  [RS_SIZE];
    operand_t             r_op1     [RS_SIZE];
    operand_t             r_op2     [RS_SIZE];
    logic [DATA_W-1:0]    r_imm     [RS_SIZE];
    logic [DATA_W-1:0]    r_pc      [RS_SIZE];
    logic [ROB_POS_W-1:0] r_rob_pos [RS_SIZE];
    logic [RS_CNT_W-1:0]  r_count;

    logic                 r_alu_enable;
    logic [OPENUM_W-1:0]  r_alu_openum;
    logic [DATA_W-1:0]    r_alu_val1;
    logic [DATA_W-1:0]    r_alu_val2;
    logic [DATA_W-1:0]    r_alu_imm;
    logic [DATA_W-1:0]    r_alu_pc;
    logic [ROB_POS_W-1:0] r_alu_rob_pos;

    logic [RS_SIZE-1:0]   w_free;
    logic [RS_SIZE-1:0]   w_ready;
    operand_t             w_op1_next [RS_SIZE];
    operand_t             w_op2_next [RS_SIZE];
    operand_t             w_issue_op1;
    operand_t             w_issue_op2;
    logic                 w_free_found;
    logic [RS_IDX_W-1:0]  w_free_idx;
    logic                 w_ready_found;
    logic [RS_IDX_W-1:0]  w_ready_idx;
    logic                 w_issue;
    logic                 w_dispatch;

    always_comb begin
        w_free  = ~r_busy;
        w_ready = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_ready[i]    = r_busy[i] && (r_op1[i].tag == '0) && (r_op2[i].tag == '0);
            w_op1_next[i] = snoop_operand(r_op1[i], alu_result_ready, alu_result_rob_pos,
                                          alu_result_val, lsb_load_result_ready,
                                          lsb_load_result_rob_pos, lsb_load_result_val);
            w_op2_next[i] = snoop_operand(r_op2[i], alu_result_ready, alu_result_rob_pos,
                                          alu_result_val, lsb_load_result_ready,
                                          lsb_load_result_rob_pos, lsb_load_result_val);
        end
    end

    // Incoming operands see the same broadcasts as resident ones, so a producer
    // finishing in the issue cycle is not missed.
    assign w_issue_op1 = snoop_operand(operand_t'({issue_rs1_rob_pos, issue_rs1_val}),
                                       alu_result_ready, alu_result_rob_pos, alu_result_val,
                                       lsb_load_result_ready, lsb_load_result_rob_pos,
                                       lsb_load_result_val);
    assign w_issue_op2 = snoop_operand(operand_t'({issue_rs2_rob_pos, issue_rs2_val}),
                                       alu_result_ready, alu_result_rob_pos, alu_result_val,
                                       lsb_load_result_ready, lsb_load_result_rob_pos,
                                       lsb_load_result_val);

    reservation_station_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_sel (
        .i_vec   (w_free),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    reservation_station_select #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_sel (
        .i_vec   (w_ready),
        .o_found (w_ready_found),
        .o_idx   (w_ready_idx)
    );

    assign w_issue    = issue_enable && rs_enable && w_free_found;
    assign w_dispatch = w_ready_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy        <= '0;
            r_count       <= '0;
            r_alu_enable  <= FALSE;
            r_alu_openum  <= '0;
            r_alu_val1    <= '0;
            r_alu_val2    <= '0;
            r_alu_imm     <= '0;
            r_alu_pc      <= '0;
            r_alu_rob_pos <= '0;
        end else if (!rdy) begin
            r_alu_enable <= FALSE;
        end else if (clr) begin
            r_busy       <= '0;
            r_count      <= '0;
            r_alu_enable <= FALSE;
        end else begin
            r_alu_enable <= w_dispatch;
            if (w_dispatch) begin
                r_busy[w_ready_idx] <= FALSE;
                r_alu_openum        <= r_openum[w_ready_idx];
                r_alu_val1          <= r_op1[w_ready_idx].val;
                r_alu_val2          <= r_op2[w_ready_idx].val;
                r_alu_imm           <= r_imm[w_ready_idx];
                r_alu_pc            <= r_pc[w_ready_idx];
                r_alu_rob_pos       <= r_rob_pos[w_ready_idx];
            end
            if (w_issue) begin
                r_busy[w_free_idx] <= TRUE;
            end
            case ({w_issue, w_dispatch})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload carries no reset; busy alone decides whether it is meaningful.
    always_ff @(posedge clk) begin
        if (!rst && rdy && !clr) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i]) begin
                    r_op1[i] <= w_op1_next[i];
                    r_op2[i] <= w_op2_next[i];
                end
            end
            if (w_issue) begin
                r_openum[w_free_idx]  <= issue_openum;
                r_op1[w_free_idx]     <= w_issue_op1;
                r_op2[w_free_idx]     <= w_issue_op2;
                r_imm[w_free_idx]     <= issue_imm;
                r_pc[w_free_idx]      <= issue_pc;
                r_rob_pos[w_free_idx] <= issue_rob_pos;
            end
        end
    end

    assign rs_full     = (r_count >= FULL_MARK);
    assign alu_enable  = r_alu_enable;
    assign alu_openum  = r_alu_openum;
    assign alu_val1    = r_alu_val1;
    assign alu_val2    = r_alu_val2;
    assign alu_imm     = r_alu_imm;
    assign alu_pc      = r_alu_pc;
    assign alu_rob_pos = r_alu_rob_pos;

endmodule

// File: tb/tb_reservation_station.sv
// Directed testbench for reservation_station: one task per scenario, inputs
// driven on the falling edge, outputs sampled on the falling edge.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 rdy;
    logic                 clr;
    logic                 issue_enable;
    logic                 rs_enable;
    logic [OPENUM_W-1:0]  issue_openum;
    logic [DATA_W-1:0]    issue_rs1_val;
    logic [ROB_POS_W-1:0] issue_rs1_rob_pos;
    logic [DATA_W-1:0]    issue_rs2_val;
    logic [ROB_POS_W-1:0] issue_rs2_rob_pos;
    logic [DATA_W-1:0]    issue_imm;
    logic [DATA_W-1:0]    issue_pc;
    logic [ROB_POS_W-1:0] issue_rob_pos;
    logic                 alu_result_ready;
    logic [ROB_POS_W-1:0] alu_result_rob_pos;
    logic [DATA_W-1:0]    alu_result_val;
    logic                 lsb_load_result_ready;
    logic [ROB_POS_W-1:0] lsb_load_result_rob_pos;
    logic [DATA_W-1:0]    lsb_load_result_val;
    logic                 rs_full;
    logic                 alu_enable;
    logic [OPENUM_W-1:0]  alu_openum;
    logic [DATA_W-1:0]    alu_val1;
    logic [DATA_W-1:0]    alu_val2;
    logic [DATA_W-1:0]    alu_imm;
    logic [DATA_W-1:0]    alu_pc;
    logic [ROB_POS_W-1:0] alu_rob_pos;

    int n_compared;
    int n_mismatched;

    reservation_station dut (
        .clk                     (clk),
        .rst                     (rst),
        .rdy                     (rdy),
        .clr                     (clr),
        .issue_enable            (issue_enable),
        .rs_enable               (rs_enable),
        .issue_openum            (issue_openum),
        .issue_rs1_val           (issue_rs1_val),
        .issue_rs1_rob_pos       (issue_rs1_rob_pos),
        .issue_rs2_val           (issue_rs2_val),
        .issue_rs2_rob_pos       (issue_rs2_rob_pos),
        .issue_imm               (issue_imm),
        .issue_pc                (issue_pc),
        .issue_rob_pos           (issue_rob_pos),
        .alu_result_ready        (alu_result_ready),
        .alu_result_rob_pos      (alu_result_rob_pos),
        .alu_result_val          (alu_result_val),
        .lsb_load_result_ready   (lsb_load_result_ready),
        .lsb_load_result_rob_pos (lsb_load_result_rob_pos),
        .lsb_load_result_val     (lsb_load_result_val),
        .rs_full                 (rs_full),
        .alu_enable              (alu_enable),
        .alu_openum              (alu_openum),
        .alu_val1                (alu_val1),
        .alu_val2                (alu_val2),
        .alu_imm                 (alu_imm),
        .alu_pc                  (alu_pc),
        .alu_rob_pos             (alu_rob_pos)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Occupancy model guarding against issue into a completely full station.
    int   tb_live = 0;
    logic p_rst   = 1'b1;
    logic p_clr   = 1'b0;
    logic p_rdy   = 1'b0;
    logic p_issue = 1'b0;

    always @(posedge clk) begin
        p_rst   <= rst;
        p_clr   <= clr;
        p_rdy   <= rdy;
        p_issue <= issue_enable && rs_enable;
        if (!rst && !clr && rdy && issue_enable && rs_enable && tb_live >= RS_SIZE) begin
            n_mismatched++;
            $error("FAIL protocol_issue_into_full: live %0d limit %0d", tb_live, RS_SIZE);
        end
    end

    always @(negedge clk) begin
        if (p_rst || p_clr) tb_live <= 0;
        else if (p_rdy) tb_live <= tb_live + (p_issue ? 1 : 0) - (alu_enable ? 1 : 0);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue_instr(input logic [OPENUM_W-1:0] op,
                               input logic [DATA_W-1:0] v1, input logic [ROB_POS_W-1:0] t1,
                               input logic [DATA_W-1:0] v2, input logic [ROB_POS_W-1:0] t2,
                               input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pc,
                               input logic [ROB_POS_W-1:0] rob);
        issue_enable      = 1'b1;
        rs_enable         = 1'b1;
        issue_openum      = op;
        issue_rs1_val     = v1;
        issue_rs1_rob_pos = t1;
        issue_rs2_val     = v2;
        issue_rs2_rob_pos = t2;
        issue_imm         = imm;
        issue_pc          = pc;
        issue_rob_pos     = rob;
        @(negedge clk);
        issue_enable = 1'b0;
        rs_enable    = 1'b0;
    endtask

    task automatic flush_quiet();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL reset_en: got %0b want 0", alu_enable); end
        n_compared++; if (rs_full !== 1'b0) begin n_mismatched++; $display("FAIL reset_full: got %0b want 0", rs_full); end
        n_compared++; if (alu_val1 !== 32'd0) begin n_mismatched++; $display("FAIL reset_val1: got %0h want 0", alu_val1); end
        n_compared++; if (alu_val2 !== 32'd0) begin n_mismatched++; $display("FAIL reset_val2: got %0h want 0", alu_val2); end
        n_compared++; if (alu_rob_pos !== 5'd0) begin n_mismatched++; $display("FAIL reset_rob: got %0d want 0", alu_rob_pos); end
        n_compared++; if (alu_pc !== 32'd0) begin n_mismatched++; $display("FAIL reset_pc: got %0h want 0", alu_pc); end
        rst = 1'b0;
        tick();
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL reset_idle_en: got %0b want 0", alu_enable); end
    endtask

    task automatic test_ready_issue();
        issue_instr(OP_ADD, 32'd5, 5'd0, 32'd7, 5'd0, 32'h10, 32'h100, 5'd3);
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL ready_early_en: got %0b want 0", alu_enable); end
        tick();
        n_compared++; if (alu_enable !== 1'b1) begin n_mismatched++; $display("FAIL ready_en: got %0b want 1", alu_enable); end
        n_compared++; if (alu_val1 !== 32'd5) begin n_mismatched++; $display("FAIL ready_val1: got %0h want 5", alu_val1); end
        n_compared++; if (alu_val2 !== 32'd7) begin n_mismatched++; $display("FAIL ready_val2: got %0h want 7", alu_val2); end
        n_compared++; if (alu_rob_pos !== 5'd3) begin n_mismatched++; $display("FAIL ready_rob: got %0d want 3", alu_rob_pos); end
        n_compared++; if (alu_openum !== OP_ADD) begin n_mismatched++; $display("FAIL ready_op: got %0d want %0d", alu_openum, OP_ADD); end
        n_compared++; if (alu_imm !== 32'h10) begin n_mismatched++; $display("FAIL ready_imm: got %0h want 10", alu_imm); end
        n_compared++; if (alu_pc !== 32'h100) begin n_mismatched++; $display("FAIL ready_pc: got %0h want 100", alu_pc); end
        tick();
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL ready_pulse_en: got %0b want 0", alu_enable); end
        n_compared++; if (alu_val1 !== 32'd5) begin n_mismatched++; $display("FAIL ready_hold_val1: got %0h want 5", alu_val1); end
    endtask

    task automatic test_wakeup();
        issue_instr(OP_SUB, 32'd0, 5'd4, 32'd2, 5'd0, 32'd0, 32'h104, 5'd7);
        tick();
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL wakeup_blocked_en: got %0b want 0", alu_enable); end
        alu_result_ready   = 1'b1;
        alu_result_rob_pos = 5'd4;
        alu_result_val     = 32'h55;
        tick();
        alu_result_ready = 1'b0;
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL wakeup_edge_en: got %0b want 0", alu_enable); end
        tick();
        n_compared++; if (alu_enable !== 1'b1) begin n_mismatched++; $display("FAIL wakeup_en: got %0b want 1", alu_enable); end
        n_compared++; if (alu_val1 !== 32'h55) begin n_mismatched++; $display("FAIL wakeup_val1: got %0h want 55", alu_val1); end
        n_compared++; if (alu_val2 !== 32'd2) begin n_mismatched++; $display("FAIL wakeup_val2: got %0h want 2", alu_val2); end
        n_compared++; if (alu_rob_pos !== 5'd7) begin n_mismatched++; $display("FAIL wakeup_rob: got %0d want 7", alu_rob_pos); end
        tick();
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL wakeup_pulse_en: got %0b want 0", alu_enable); end
    endtask

    task automatic test_same_cycle();
        lsb_load_result_ready   = 1'b1;
        lsb_load_result_rob_pos = 5'd6;
        lsb_load_result_val     = 32'd9;
        issue_instr(OP_XOR, 32'd3, 5'd0, 32'd0, 5'd6, 32'd0, 32'h108, 5'd8);
        lsb_load_result_ready = 1'b0;
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL same_early_en: got %0b want 0", alu_enable); end
        tick();
        n_compared++; if (alu_enable !== 1'b1) begin n_mismatched++; $display("FAIL same_en: got %0b want 1", alu_enable); end
        n_compared++; if (alu_val2 !== 32'd9) begin n_mismatched++; $display("FAIL same_val2: got %0h want 9", alu_val2); end
        n_compared++; if (alu_val1 !== 32'd3) begin n_mismatched++; $display("FAIL same_val1: got %0h want 3", alu_val1); end
        n_compared++; if (alu_rob_pos !== 5'd8) begin n_mismatched++; $display("FAIL same_rob: got %0d want 8", alu_rob_pos); end
        tick();
    endtask

    task automatic test_back_to_back();
        issue_instr(OP_ADD, 32'd1, 5'd0, 32'd1, 5'd0, 32'd0, 32'h200, 5'd11);
        issue_instr(OP_ADD, 32'd2, 5'd0, 32'd2, 5'd0, 32'd0, 32'h204, 5'd12);
        n_compared++; if (alu_enable !== 1'b1) begin n_mismatched++; $display("FAIL b2b_first_en: got %0b want 1", alu_enable); end
        n_compared++; if (alu_rob_pos !== 5'd11) begin n_mismatched++; $display("FAIL b2b_first_rob: got %0d want 11", alu_rob_pos); end
        tick();
        n_compared++; if (alu_enable !== 1'b1) begin n_mismatched++; $display("FAIL b2b_second_en: got %0b want 1", alu_enable); end
        n_compared++; if (alu_rob_pos !== 5'd12) begin n_mismatched++; $display("FAIL b2b_second_rob: got %0d want 12", alu_rob_pos); end
        n_compared++; if (alu_val1 !== 32'd2) begin n_mismatched++; $display("FAIL b2b_second_val1: got %0h want 2", alu_val1); end
        tick();
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL b2b_idle_en: got %0b want 0", alu_enable); end
    endtask

    task automatic test_capacity();
        for (int k = 0; k < RS_SIZE - 1; k++) begin
            issue_instr(OP_ADD, 32'd0, 5'(k + 1), 32'd1, 5'd0, 32'd0, 32'(32'h300 + 4 * k), 5'(16 + k));
            if (k == RS_SIZE - 3) begin
                n_compared++; if (rs_full !== 1'b0) begin n_mismatched++; $display("FAIL cap_14_full: got %0b want 0", rs_full); end
            end
        end
        n_compared++; if (rs_full !== 1'b1) begin n_mismatched++; $display("FAIL cap_15_full: got %0b want 1", rs_full); end
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL cap_blocked_en: got %0b want 0", alu_enable); end
        alu_result_ready   = 1'b1;
        alu_result_rob_pos = 5'd1;
        alu_result_val     = 32'h77;
        tick();
        alu_result_ready = 1'b0;
        n_compared++; if (rs_full !== 1'b1) begin n_mismatched++; $display("FAIL cap_wake_full: got %0b want 1", rs_full); end
        tick();
        n_compared++; if (alu_enable !== 1'b1) begin n_mismatched++; $display("FAIL cap_disp_en: got %0b want 1", alu_enable); end
        n_compared++; if (alu_rob_pos !== 5'd16) begin n_mismatched++; $display("FAIL cap_disp_rob: got %0d want 16", alu_rob_pos); end
        n_compared++; if (alu_val1 !== 32'h77) begin n_mismatched++; $display("FAIL cap_disp_val1: got %0h want 77", alu_val1); end
        n_compared++; if (rs_full !== 1'b0) begin n_mismatched++; $display("FAIL cap_freed_full: got %0b want 0", rs_full); end
        flush_quiet();
    endtask

    task automatic test_priority();
        for (int k = 0; k < 6; k++) begin
            issue_instr(OP_OR, 32'd0, ((k == 2) || (k == 5)) ? 5'd12 : 5'd13, 32'd0, 5'd0,
                        32'd0, 32'd0, 5'(10 + k));
        end
        alu_result_ready   = 1'b1;
        alu_result_rob_pos = 5'd12;
        alu_result_val     = 32'hAA;
        tick();
        alu_result_ready = 1'b0;
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL prio_edge_en: got %0b want 0", alu_enable); end
        tick();
        n_compared++; if (alu_enable !== 1'b1) begin n_mismatched++; $display("FAIL prio_first_en: got %0b want 1", alu_enable); end
        n_compared++; if (alu_rob_pos !== 5'd12) begin n_mismatched++; $display("FAIL prio_first_rob: got %0d want 12", alu_rob_pos); end
        n_compared++; if (alu_val1 !== 32'hAA) begin n_mismatched++; $display("FAIL prio_first_val1: got %0h want aa", alu_val1); end
        tick();
        n_compared++; if (alu_enable !== 1'b1) begin n_mismatched++; $display("FAIL prio_second_en: got %0b want 1", alu_enable); end
        n_compared++; if (alu_rob_pos !== 5'd15) begin n_mismatched++; $display("FAIL prio_second_rob: got %0d want 15", alu_rob_pos); end
        tick();
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL prio_done_en: got %0b want 0", alu_enable); end
        flush_quiet();
    endtask

    task automatic test_flush();
        for (int k = 0; k < 8; k++) begin
            issue_instr(OP_AND, 32'd0, 5'd30, 32'd0, 5'd0, 32'd0, 32'd0, 5'(k + 1));
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL flush_en: got %0b want 0", alu_enable); end
        n_compared++; if (rs_full !== 1'b0) begin n_mismatched++; $display("FAIL flush_full: got %0b want 0", rs_full); end
        alu_result_ready   = 1'b1;
        alu_result_rob_pos = 5'd30;
        alu_result_val     = 32'd1;
        tick();
        alu_result_ready = 1'b0;
        tick();
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL flush_stale_en: got %0b want 0", alu_enable); end
        for (int k = 0; k < 7; k++) begin
            issue_instr(OP_AND, 32'd0, 5'd29, 32'd0, 5'd0, 32'd0, 32'd0, 5'(k + 1));
        end
        n_compared++; if (rs_full !== 1'b0) begin n_mismatched++; $display("FAIL flush_count_full: got %0b want 0", rs_full); end
        flush_quiet();
    endtask

    task automatic test_freeze();
        issue_instr(OP_AND, 32'd1, 5'd0, 32'd2, 5'd0, 32'd0, 32'h400, 5'd9);
        rdy = 1'b0;
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL freeze_issue_en: got %0b want 0", alu_enable); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL freeze_hold_en: cycle %0d got %0b want 0", c, alu_enable); end
        end
        rdy = 1'b1;
        tick();
        n_compared++; if (alu_enable !== 1'b1) begin n_mismatched++; $display("FAIL freeze_resume_en: got %0b want 1", alu_enable); end
        n_compared++; if (alu_rob_pos !== 5'd9) begin n_mismatched++; $display("FAIL freeze_resume_rob: got %0d want 9", alu_rob_pos); end
        tick();
        n_compared++; if (alu_enable !== 1'b0) begin n_mismatched++; $display("FAIL freeze_done_en: got %0b want 0", alu_enable); end
    endtask

    initial begin
        n_compared              = 0;
        n_mismatched            = 0;
        rst                     = 1'b1;
        rdy                     = 1'b1;
        clr                     = 1'b0;
        issue_enable            = 1'b0;
        rs_enable               = 1'b0;
        issue_openum            = '0;
        issue_rs1_val           = '0;
        issue_rs1_rob_pos       = '0;
        issue_rs2_val           = '0;
        issue_rs2_rob_pos       = '0;
        issue_imm               = '0;
        issue_pc                = '0;
        issue_rob_pos           = '0;
        alu_result_ready        = 1'b0;
        alu_result_rob_pos      = '0;
        alu_result_val          = '0;
        lsb_load_result_ready   = 1'b0;
        lsb_load_result_rob_pos = '0;
        lsb_load_result_val     = '0;

        test_reset();
        test_ready_issue();
        test_wakeup();
        test_same_cycle();
        test_back_to_back();
        test_capacity();
        test_priority();
        test_flush();
        test_freeze();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
